// File: rtl/gcd_job_seq.sv
// rtl/gcd_job_seq.sv - tagged operand FIFO and one-at-a-time job sequencer for the gcd engine
// Results are captured with tag and saturating cycle count and held on a valid/ready output.
module gcd_job_seq #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic [CNT_W-1:0]         out_cycles,
    output logic                     gcd_start,
    output logic [31:0]              gcd_a,
    output logic [31:0]              gcd_b,
    input  logic [31:0]              gcd_result,
    input  logic                     gcd_done,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      mem_a_q   [DEPTH];
    logic [31:0]      mem_a_d   [DEPTH];
    logic [31:0]      mem_b_q   [DEPTH];
    logic [31:0]      mem_b_d   [DEPTH];
    logic [TAG_W-1:0] mem_tag_q [DEPTH];
    logic [TAG_W-1:0] mem_tag_d [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic             gcd_start_q, gcd_start_d;
    logic [31:0]      gcd_a_q, gcd_a_d;
    logic [31:0]      gcd_b_q, gcd_b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [CNT_W-1:0] out_cycles_q, out_cycles_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic issue;

    // A pop in the same cycle never frees a slot for a push while full.
    assign fifo_full  = (occ_q == OCC_FULL);
    assign fifo_empty = (occ_q == '0);
    assign push       = in_valid && !fifo_full;
    // Issue only when the result slot will be free by the time the engine finishes.
    assign issue      = (state_q == ST_IDLE) && !fifo_empty && (!out_valid_q || out_ready);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (issue)    state_d = ST_WAIT;
            ST_WAIT: if (gcd_done) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        mem_a_d      = mem_a_q;
        mem_b_d      = mem_b_q;
        mem_tag_d    = mem_tag_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q + OCC_W'(push) - OCC_W'(issue);
        gcd_start_d  = 1'b0;
        gcd_a_d      = gcd_a_q;
        gcd_b_d      = gcd_b_q;
        tag_d        = tag_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        out_cycles_d = out_cycles_q;

        if (push) begin
            mem_a_d[wr_ptr_q]   = in_a;
            mem_b_d[wr_ptr_q]   = in_b;
            mem_tag_d[wr_ptr_q] = in_tag;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (issue) begin
            gcd_a_d     = mem_a_q[rd_ptr_q];
            gcd_b_d     = mem_b_q[rd_ptr_q];
            tag_d       = mem_tag_q[rd_ptr_q];
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            gcd_start_d = 1'b1;
            cnt_d       = '0;
        end

        if (state_q == ST_WAIT) begin
            if (gcd_done) begin
                out_result_d = gcd_result;
                out_tag_d    = tag_q;
                out_cycles_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
                out_valid_d  = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_q[i]   <= '0;
                mem_b_q[i]   <= '0;
                mem_tag_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            gcd_start_q  <= 1'b0;
            gcd_a_q      <= '0;
            gcd_b_q      <= '0;
            tag_q        <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_cycles_q <= '0;
        end else begin
            mem_a_q      <= mem_a_d;
            mem_b_q      <= mem_b_d;
            mem_tag_q    <= mem_tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            gcd_start_q  <= gcd_start_d;
            gcd_a_q      <= gcd_a_d;
            gcd_b_q      <= gcd_b_d;
            tag_q        <= tag_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            out_cycles_q <= out_cycles_d;
        end
    end

    // Output assignments
    always_comb begin
        in_ready   = !fifo_full;
        out_valid  = out_valid_q;
        out_result = out_result_q;
        out_tag    = out_tag_q;
        out_cycles = out_cycles_q;
        gcd_start  = gcd_start_q;
        gcd_a      = gcd_a_q;
        gcd_b      = gcd_b_q;
        occupancy  = occ_q;
        busy       = (state_q == ST_WAIT);
    end

endmodule
